// File: rtl/dds_key_ctrl.sv
// dds_key_ctrl: front-panel key handling for the DDS generator.
// Three raw active-low keys are synchronised and debounced. Debounced
// falling edges (presses) drive a field-select FSM that edits the
// waveform select, the frequency tuning word and the amplitude index.
// A one-cycle cfg_update strobe follows every real settings change.
module dds_key_ctrl #(
  parameter int unsigned DEB_CYCLES = 1_000_000,
  parameter logic [31:0] FW_INIT    = 32'd85899,
  parameter logic [31:0] FW_STEP    = 32'd85899,
  parameter logic [31:0] FW_MIN     = 32'd85899,
  parameter logic [31:0] FW_MAX     = 32'd858993459
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_mode,
  input  logic        key_up,
  input  logic        key_down,
  output logic [1:0]  field_sel,
  output logic [1:0]  wave_sel,
  output logic [31:0] freq_word,
  output logic [2:0]  amp_sel,
  output logic        cfg_update
);

  localparam int unsigned     CW       = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEB_CYCLES - 32'd1);
  // Saturation limits evaluated in 33 bits so the step can never wrap.
  localparam logic [32:0]     UP_LIM   = {1'b0, FW_MAX} - {1'b0, FW_STEP};
  localparam logic [32:0]     DN_LIM   = {1'b0, FW_MIN} + {1'b0, FW_STEP};

  typedef enum logic [1:0] {
    ST_WAVE = 2'd0,
    ST_FREQ = 2'd1,
    ST_AMP  = 2'd2,
    ST_BAD  = 2'd3
  } field_e;

  // Key vector: bit 0 = mode, bit 1 = up, bit 2 = down.
  logic [2:0]    keys_s;
  logic [2:0]    s1_q;
  logic [2:0]    s2_q;
  logic [2:0]    stable_q;
  logic [2:0]    stable_dly_q;
  logic [CW-1:0] cnt_q [3];
  logic [2:0]    press_s;
  logic          mode_p_s;
  logic          up_p_s;
  logic          down_p_s;

  field_e        state_q, state_d;
  logic [1:0]    wave_q, wave_d;
  logic [31:0]   freq_q, freq_d;
  logic [2:0]    amp_q, amp_d;
  logic          cfg_q;
  logic          changed_s;
  logic [32:0]   freq_x_s;

  assign keys_s = {key_down, key_up, key_mode};

  // Synchronise raw keys, debounce each one and keep a delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q         <= 3'b111;
      s2_q         <= 3'b111;
      stable_q     <= 3'b111;
      stable_dly_q <= 3'b111;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= {CW{1'b0}};
      end
    end else begin
      s1_q         <= keys_s;
      s2_q         <= s1_q;
      stable_dly_q <= stable_q;
      for (int i = 0; i < 3; i++) begin
        if (s2_q[i] == stable_q[i]) begin
          cnt_q[i] <= {CW{1'b0}};
        end else if (cnt_q[i] == CNT_LAST) begin
          stable_q[i] <= s2_q[i];
          cnt_q[i]    <= {CW{1'b0}};
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Debounced falling edges; mode beats up/down, and up with down cancels out.
  assign press_s  = stable_dly_q & ~stable_q;
  assign mode_p_s = press_s[0];
  assign up_p_s   = press_s[1] & ~press_s[2] & ~press_s[0];
  assign down_p_s = press_s[2] & ~press_s[1] & ~press_s[0];
  assign freq_x_s = {1'b0, freq_q};

  // Field-select next state and edits of the setting owned by the current field.
  always_comb begin
    state_d = state_q;
    wave_d  = wave_q;
    freq_d  = freq_q;
    amp_d   = amp_q;
    case (state_q)
      ST_WAVE: begin
        if (mode_p_s) begin
          state_d = ST_FREQ;
        end else if (up_p_s) begin
          wave_d = wave_q + 2'd1;
        end else if (down_p_s) begin
          wave_d = wave_q - 2'd1;
        end else begin
          wave_d = wave_q;
        end
      end
      ST_FREQ: begin
        if (mode_p_s) begin
          state_d = ST_AMP;
        end else if (up_p_s) begin
          if (freq_x_s > UP_LIM) begin
            freq_d = FW_MAX;
          end else begin
            freq_d = freq_q + FW_STEP;
          end
        end else if (down_p_s) begin
          if (freq_x_s < DN_LIM) begin
            freq_d = FW_MIN;
          end else begin
            freq_d = freq_q - FW_STEP;
          end
        end else begin
          freq_d = freq_q;
        end
      end
      ST_AMP: begin
        if (mode_p_s) begin
          state_d = ST_WAVE;
        end else if (up_p_s && (amp_q != 3'd7)) begin
          amp_d = amp_q + 3'd1;
        end else if (down_p_s && (amp_q != 3'd0)) begin
          amp_d = amp_q - 3'd1;
        end else begin
          amp_d = amp_q;
        end
      end
      default: begin
        state_d = ST_WAVE;
      end
    endcase
  end

  assign changed_s = (wave_d != wave_q) || (freq_d != freq_q) || (amp_d != amp_q);

  // Register field state, settings and the change strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_WAVE;
      wave_q  <= 2'd0;
      freq_q  <= FW_INIT;
      amp_q   <= 3'd0;
      cfg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wave_q  <= wave_d;
      freq_q  <= freq_d;
      amp_q   <= amp_d;
      cfg_q   <= changed_s;
    end
  end

  assign field_sel  = state_q;
  assign wave_sel   = wave_q;
  assign freq_word  = freq_q;
  assign amp_sel    = amp_q;
  assign cfg_update = cfg_q;

endmodule

// File: tb/tb_dds_key_ctrl.sv
// Directed bench for dds_key_ctrl with short debounce and small frequency limits.
module tb_dds_key_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_mode;
  logic        key_up;
  logic        key_down;
  logic [1:0]  field_sel;
  logic [1:0]  wave_sel;
  logic [31:0] freq_word;
  logic [2:0]  amp_sel;
  logic        cfg_update;

  dds_key_ctrl #(
    .DEB_CYCLES(4),
    .FW_INIT   (32'd500),
    .FW_STEP   (32'd100),
    .FW_MIN    (32'd100),
    .FW_MAX    (32'd1000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_mode  (key_mode),
    .key_up    (key_up),
    .key_down  (key_down),
    .field_sel (field_sel),
    .wave_sel  (wave_sel),
    .freq_word (freq_word),
    .amp_sel   (amp_sel),
    .cfg_update(cfg_update)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  field;
    logic [1:0]  wave;
    logic [31:0] freq;
    logic [2:0]  amp;
    int          strobes;
  } exp_t;

  exp_t sb[$];
  int checks  = 0;
  int errors  = 0;
  int cyc     = 0;
  int strobes = 0;
  int last_sc = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [1:0] ef, input logic [1:0] ew,
                         input logic [31:0] efr, input logic [2:0] ea);
    chk({tag, "_field"}, field_sel, ef);
    chk({tag, "_wave"},  wave_sel,  ew);
    chk({tag, "_freq"},  freq_word, efr);
    chk({tag, "_amp"},   amp_sel,   ea);
  endtask

  // Advance n cycles sampling on the falling edge, counting strobes.
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
      if (cfg_update === 1'b1) begin
        strobes++;
        last_sc = cyc;
      end
    end
  endtask

  // k: bit0 mode, bit1 up, bit2 down; a set bit holds that key low.
  task automatic drive(input logic [2:0] k);
    key_mode = ~k[0];
    key_up   = ~k[1];
    key_down = ~k[2];
  endtask

  // Hold keys 10 cycles, release for 12, then check against the scoreboard.
  task automatic press(input string tag, input logic [2:0] k, input logic [1:0] ef,
                       input logic [1:0] ew, input logic [31:0] efr, input logic [2:0] ea,
                       input int es);
    exp_t e;
    int   start;
    e = '{ef, ew, efr, ea, es};
    sb.push_back(e);
    strobes = 0;
    start   = cyc;
    drive(k);
    tick(10);
    drive(3'b000);
    tick(12);
    e = sb.pop_front();
    chk({tag, "_strobes"}, strobes, e.strobes);
    if (e.strobes == 1) chk({tag, "_latency"}, last_sc - start, 7);
    chk_out(tag, e.field, e.wave, e.freq, e.amp);
  endtask

  initial begin
    int f;
    int a;
    // Reset with all keys held low.
    drive(3'b111);
    rst_n = 1'b0;
    tick(3);
    chk_out("in_reset", 2'd0, 2'd0, 32'd500, 3'd0);
    chk("in_reset_cfg", cfg_update, 0);
    rst_n   = 1'b1;
    strobes = 0;
    tick(2);
    chk("rst_exit_field", field_sel, 0);
    tick(18);
    chk("rst_held_strobes", strobes, 0);
    chk("rst_held_wave", wave_sel, 0);
    chk("rst_held_freq", freq_word, 500);
    chk("rst_held_amp", amp_sel, 0);
    drive(3'b000);
    tick(12);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    chk_out("clean_rst", 2'd0, 2'd0, 32'd500, 3'd0);

    // Waveform select wraps modulo 4.
    for (int i = 1; i <= 4; i++) press("wave_up", 3'b010, 2'd0, 2'(i % 4), 32'd500, 3'd0, 1);

    // Frequency word saturates at both ends.
    press("mode_to_freq", 3'b001, 2'd1, 2'd0, 32'd500, 3'd0, 0);
    for (int i = 1; i <= 6; i++) begin
      f = 500 + 100 * i;
      if (f > 1000) f = 1000;
      press("freq_up", 3'b010, 2'd1, 2'd0, 32'(f), 3'd0, (i < 6) ? 1 : 0);
    end
    for (int i = 1; i <= 10; i++) begin
      f = 1000 - 100 * i;
      if (f < 100) f = 100;
      press("freq_down", 3'b100, 2'd1, 2'd0, 32'(f), 3'd0, (i < 10) ? 1 : 0);
    end

    // Amplitude index saturates at 0 and 7.
    press("mode_to_amp", 3'b001, 2'd2, 2'd0, 32'd100, 3'd0, 0);
    for (int i = 1; i <= 9; i++) press("amp_down", 3'b100, 2'd2, 2'd0, 32'd100, 3'd0, 0);
    for (int i = 1; i <= 8; i++) begin
      a = (i > 7) ? 7 : i;
      press("amp_up", 3'b010, 2'd2, 2'd0, 32'd100, 3'(a), (i < 8) ? 1 : 0);
    end
    press("mode_to_wave", 3'b001, 2'd0, 2'd0, 32'd100, 3'd7, 0);

    // Bouncing up key: short lows are ignored, steady low gives one step.
    strobes = 0;
    repeat (5) begin
      drive(3'b010);
      tick(3);
      drive(3'b000);
      tick(2);
    end
    chk("bounce_none", strobes, 0);
    chk("bounce_wave_hold", wave_sel, 0);
    begin
      int start;
      start = cyc;
      drive(3'b010);
      tick(10);
      drive(3'b000);
      tick(12);
      chk("bounce_strobes", strobes, 1);
      chk("bounce_latency", last_sc - start, 7);
      chk("bounce_wave", wave_sel, 1);
    end

    // Simultaneous presses.
    press("mode_to_freq2", 3'b001, 2'd1, 2'd1, 32'd100, 3'd7, 0);
    press("mode_plus_up", 3'b011, 2'd2, 2'd1, 32'd100, 3'd7, 0);
    press("up_plus_down", 3'b110, 2'd2, 2'd1, 32'd100, 3'd7, 0);

    // Reset in the middle of a debounce count.
    drive(3'b010);
    tick(3);
    rst_n = 1'b0;
    #1;
    chk_out("mid_reset", 2'd0, 2'd0, 32'd500, 3'd0);
    chk("mid_reset_cfg", cfg_update, 0);
    tick(2);
    drive(3'b000);
    rst_n   = 1'b1;
    strobes = 0;
    tick(15);
    chk("post_reset_strobes", strobes, 0);
    chk_out("post_reset", 2'd0, 2'd0, 32'd500, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
